// File: rtl/m_unit_scheduler.sv
// Launch/hold/writeback sequencer between EX and the multi-cycle M unit.
// Handles flush, a hang watchdog and a retired-op counter.
module m_unit_scheduler #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_valid,
  input  logic [31:0] ex_instruction,
  input  logic [31:0] ex_rs1_val,
  input  logic [31:0] ex_rs2_val,
  input  logic [4:0]  ex_rd,
  input  logic        flush,
  output logic        m_valid,
  output logic [31:0] m_instruction,
  output logic [31:0] m_rs1,
  output logic [31:0] m_rs2,
  output logic [4:0]  m_rd,
  input  logic        m_wr,
  input  logic        m_ready,
  input  logic [31:0] m_result,
  input  logic        m_busy,
  output logic        stall,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  input  logic        wb_ready,
  output logic        timeout_err,
  output logic [31:0] m_op_count
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, DONE, DRAIN
  } state_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_n;
  logic [CW-1:0] wdog;
  logic          is_m, launch, expired;
  logic          capture, tmo_wb, tmo_set, retire;

  assign is_m = ex_valid
             && ex_instruction[6:0] == 7'b0110011
             && ex_instruction[31:25] == 7'b0000001;
  assign launch  = state == IDLE && is_m && !flush;
  assign expired = wdog >= LAST;

  assign m_valid  = state == ISSUE;
  assign wb_valid = state == DONE;

  always_comb begin
    state_n = state;
    stall   = 1'b0;
    capture = 1'b0;
    tmo_wb  = 1'b0;
    tmo_set = 1'b0;
    retire  = 1'b0;
    unique case (state)
      IDLE: begin
        stall = launch;
        if (launch) state_n = ISSUE;
      end
      ISSUE: begin
        stall   = 1'b1;
        state_n = flush ? DRAIN : WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (flush) begin
          state_n = m_ready ? IDLE : DRAIN;
        end else if (m_ready) begin
          capture = 1'b1;
          state_n = DONE;
        end else if (expired) begin
          tmo_wb  = 1'b1;
          tmo_set = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        stall = !wb_ready;
        if (flush) begin
          state_n = IDLE;
        end else if (wb_ready) begin
          retire  = 1'b1;
          state_n = IDLE;
        end
      end
      DRAIN: begin
        // only new M ops wait for the abandoned one to leave the unit
        stall = is_m;
        if (m_ready) begin
          state_n = IDLE;
        end else if (expired) begin
          tmo_set = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state         <= IDLE;
      wdog          <= '0;
      m_instruction <= '0;
      m_rs1         <= '0;
      m_rs2         <= '0;
      m_rd          <= '0;
      wb_we         <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      timeout_err   <= 1'b0;
      m_op_count    <= '0;
    end else begin
      state <= state_n;
      if (launch) begin
        m_instruction <= ex_instruction;
        m_rs1         <= ex_rs1_val;
        m_rs2         <= ex_rs2_val;
        m_rd          <= ex_rd;
        wdog          <= '0;
      end else if (state == ISSUE || state == WAIT || state == DRAIN) begin
        wdog <= wdog + CW'(1);
      end
      if (capture) begin
        wb_data <= m_result;
        wb_we   <= m_wr;
        wb_rd   <= m_rd;
      end else if (tmo_wb) begin
        wb_data <= 32'hFFFF_FFFF;
        wb_we   <= 1'b1;
        wb_rd   <= m_rd;
      end
      if (tmo_set) timeout_err <= 1'b1;
      if (retire) m_op_count <= m_op_count + 32'd1;
    end
  end

  // the unit must be idle whenever a new op is launched into it
  a_launch_idle: assert property (
    @(posedge clk) disable iff (resetn) (state == ISSUE) |-> !m_busy
  );

endmodule

// File: tb/tb_m_unit_scheduler.sv
// Directed bench for m_unit_scheduler: one task per scenario.
// A second instance with an 8-cycle watchdog covers the timeout path.
module tb_m_unit_scheduler;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_valid;
  logic [31:0] ex_instruction, ex_rs1_val, ex_rs2_val;
  logic [4:0]  ex_rd;
  logic        flush;
  logic        m_wr, m_ready, m_busy, wb_ready;
  logic [31:0] m_result;

  logic        m_valid, stall, wb_valid, wb_we, timeout_err;
  logic [31:0] m_instruction, m_rs1, m_rs2, wb_data, m_op_count;
  logic [4:0]  m_rd, wb_rd;

  logic        wd_m_valid, wd_stall, wd_wb_valid, wd_wb_we, wd_timeout_err;
  logic [31:0] wd_m_instruction, wd_m_rs1, wd_m_rs2, wd_wb_data, wd_m_op_count;
  logic [4:0]  wd_m_rd, wd_wb_rd;

  int total = 0;
  int bad = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (m_valid === 1'b1) pulses++;

  m_unit_scheduler #(.TIMEOUT_CYCLES(64)) u_dut (
    .clk(clk), .resetn(resetn), .ex_valid(ex_valid),
    .ex_instruction(ex_instruction), .ex_rs1_val(ex_rs1_val),
    .ex_rs2_val(ex_rs2_val), .ex_rd(ex_rd), .flush(flush),
    .m_valid(m_valid), .m_instruction(m_instruction), .m_rs1(m_rs1),
    .m_rs2(m_rs2), .m_rd(m_rd), .m_wr(m_wr), .m_ready(m_ready),
    .m_result(m_result), .m_busy(m_busy), .stall(stall),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_ready(wb_ready), .timeout_err(timeout_err), .m_op_count(m_op_count)
  );

  m_unit_scheduler #(.TIMEOUT_CYCLES(8)) u_wd (
    .clk(clk), .resetn(resetn), .ex_valid(ex_valid),
    .ex_instruction(ex_instruction), .ex_rs1_val(ex_rs1_val),
    .ex_rs2_val(ex_rs2_val), .ex_rd(ex_rd), .flush(flush),
    .m_valid(wd_m_valid), .m_instruction(wd_m_instruction),
    .m_rs1(wd_m_rs1), .m_rs2(wd_m_rs2), .m_rd(wd_m_rd), .m_wr(m_wr),
    .m_ready(m_ready), .m_result(m_result), .m_busy(m_busy),
    .stall(wd_stall), .wb_valid(wd_wb_valid), .wb_we(wd_wb_we),
    .wb_rd(wd_wb_rd), .wb_data(wd_wb_data), .wb_ready(wb_ready),
    .timeout_err(wd_timeout_err), .m_op_count(wd_m_op_count)
  );

  function automatic logic [31:0] rtype(input logic [6:0] f7,
                                        input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [2:0] f3, input logic [4:0] rd,
                     input logic [31:0] a, input logic [31:0] b);
    ex_valid = 1'b1;
    ex_instruction = rtype(7'h01, f3, rd);
    ex_rs1_val = a;
    ex_rs2_val = b;
    ex_rd = rd;
  endtask

  task automatic test_reset();
    #1;
    total++; if (m_valid !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL rst_in mv/stall got=%b%b exp=00", m_valid, stall); end
    cyc(); resetn = 1'b0; #1;
    total++; if ({m_valid, stall, wb_valid, wb_we, timeout_err} !== 5'b0) begin bad++; $display("FAIL rst_flags got=%b exp=00000", {m_valid, stall, wb_valid, wb_we, timeout_err}); end
    total++; if ({m_instruction, m_rs1, m_rs2, m_rd} !== '0) begin bad++; $display("FAIL rst_mregs got=%h %h %h %h exp=0", m_instruction, m_rs1, m_rs2, m_rd); end
    total++; if ({wb_data, wb_rd} !== '0) begin bad++; $display("FAIL rst_wb got=%h %h exp=0", wb_data, wb_rd); end
    total++; if (m_op_count !== 32'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", m_op_count); end
  endtask

  task automatic test_mul();
    int p0;
    p0 = pulses;
    cyc(); put(3'b000, 5'd5, 32'd7, 32'hFFFF_FFFD); #1;
    total++; if (stall !== 1'b1 || m_valid !== 1'b0) begin bad++; $display("FAIL mul_launch stall/mv got=%b%b exp=10", stall, m_valid); end
    cyc(); #1;
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL mul_issue m_valid got=%b exp=1", m_valid); end
    total++; if (m_rs1 !== 32'd7 || m_rs2 !== 32'hFFFF_FFFD || m_rd !== 5'd5) begin bad++; $display("FAIL mul_latch got=%h %h %0d exp=7 fffffffd 5", m_rs1, m_rs2, m_rd); end
    total++; if (m_instruction !== rtype(7'h01, 3'b000, 5'd5)) begin bad++; $display("FAIL mul_instr got=%h", m_instruction); end
    cyc(); #1;
    total++; if (m_valid !== 1'b0 || stall !== 1'b1) begin bad++; $display("FAIL mul_wait mv/stall got=%b%b exp=01", m_valid, stall); end
    cyc(); m_ready = 1'b1; m_result = 32'hFFFF_FFEB; m_wr = 1'b1; #1;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL mul_wb_early got=%b exp=0", wb_valid); end
    cyc(); m_ready = 1'b0; wb_ready = 1'b1; #1;
    total++; if (wb_valid !== 1'b1 || stall !== 1'b0) begin bad++; $display("FAIL mul_wb valid/stall got=%b%b exp=10", wb_valid, stall); end
    total++; if (wb_rd !== 5'd5 || wb_data !== 32'hFFFF_FFEB || wb_we !== 1'b1) begin bad++; $display("FAIL mul_wb_data got=%0d %h %b exp=5 ffffffeb 1", wb_rd, wb_data, wb_we); end
    cyc(); ex_valid = 1'b0; wb_ready = 1'b0; #1;
    total++; if (m_op_count !== 32'd1 || wb_valid !== 1'b0) begin bad++; $display("FAIL mul_count got=%0d wbv=%b exp=1 0", m_op_count, wb_valid); end
    total++; if (pulses - p0 !== 1) begin bad++; $display("FAIL mul_pulses got=%0d exp=1", pulses - p0); end
  endtask

  task automatic test_back_to_back();
    cyc(); put(3'b000, 5'd6, 32'd3, 32'd4); #1;
    cyc(); #1;
    cyc(); m_ready = 1'b1; m_result = 32'd12; #1;
    cyc(); m_ready = 1'b0; wb_ready = 1'b1; #1;
    total++; if (wb_valid !== 1'b1 || wb_data !== 32'd12 || stall !== 1'b0) begin bad++; $display("FAIL b2b_wb1 got=%b %h %b exp=1 c 0", wb_valid, wb_data, stall); end
    cyc(); wb_ready = 1'b0; put(3'b000, 5'd8, 32'd5, 32'd6); #1;
    total++; if (stall !== 1'b1 || m_op_count !== 32'd2) begin bad++; $display("FAIL b2b_relaunch got=%b %0d exp=1 2", stall, m_op_count); end
    cyc(); #1;
    total++; if (m_valid !== 1'b1 || m_rd !== 5'd8) begin bad++; $display("FAIL b2b_issue got=%b %0d exp=1 8", m_valid, m_rd); end
    cyc(); m_ready = 1'b1; m_result = 32'd30; #1;
    cyc(); m_ready = 1'b0; wb_ready = 1'b1; #1;
    total++; if (wb_data !== 32'd30 || wb_rd !== 5'd8) begin bad++; $display("FAIL b2b_wb2 got=%h %0d exp=1e 8", wb_data, wb_rd); end
    cyc(); ex_valid = 1'b0; wb_ready = 1'b0; #1;
    total++; if (m_op_count !== 32'd3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", m_op_count); end
  endtask

  task automatic test_divu_hold();
    int p0, sb;
    p0 = pulses; sb = 0;
    cyc(); put(3'b101, 5'd7, 32'd100, 32'd7); #1;
    cyc(); #1;
    total++; if (m_valid !== 1'b1 || m_instruction !== rtype(7'h01, 3'b101, 5'd7)) begin bad++; $display("FAIL divu_issue got=%b %h", m_valid, m_instruction); end
    for (int k = 1; k <= 32; k++) begin
      cyc(); m_busy = 1'b1; #1;
      if (stall !== 1'b1 || wb_valid !== 1'b0) sb++;
    end
    total++; if (sb !== 0) begin bad++; $display("FAIL divu_wait_stall got=%0d bad cycles exp=0", sb); end
    cyc(); m_busy = 1'b0; m_ready = 1'b1; m_result = 32'd14; m_wr = 1'b1; #1;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL divu_wb_early got=%b exp=0", wb_valid); end
    for (int k = 0; k < 4; k++) begin
      cyc(); m_ready = 1'b0; wb_ready = 1'b0; #1;
      total++; if (wb_valid !== 1'b1 || stall !== 1'b1) begin bad++; $display("FAIL divu_hold%0d got=%b%b exp=11", k, wb_valid, stall); end
      total++; if (wb_data !== 32'd14) begin bad++; $display("FAIL divu_data%0d got=%h exp=e", k, wb_data); end
    end
    cyc(); wb_ready = 1'b1; #1;
    total++; if (stall !== 1'b0 || wb_data !== 32'd14 || wb_rd !== 5'd7) begin bad++; $display("FAIL divu_accept got=%b %h %0d exp=0 e 7", stall, wb_data, wb_rd); end
    cyc(); wb_ready = 1'b0; ex_valid = 1'b0; #1;
    total++; if (m_op_count !== 32'd4) begin bad++; $display("FAIL divu_count got=%0d exp=4", m_op_count); end
    total++; if (pulses - p0 !== 1) begin bad++; $display("FAIL divu_pulses got=%0d exp=1", pulses - p0); end
  endtask

  task automatic test_flush_wait();
    cyc(); put(3'b000, 5'd3, 32'd1, 32'd1); #1;
    cyc(); #1;
    cyc(); flush = 1'b1; ex_valid = 1'b0; #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL fw_wait_stall got=%b exp=1", stall); end
    cyc(); flush = 1'b0; ex_valid = 1'b1; ex_instruction = rtype(7'h00, 3'b000, 5'd4); #1;
    total++; if (stall !== 1'b0 || wb_valid !== 1'b0) begin bad++; $display("FAIL fw_add_flows got=%b %b exp=0 0", stall, wb_valid); end
    cyc(); m_ready = 1'b1; m_result = 32'd99; #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL fw_drain_stall got=%b exp=0", stall); end
    cyc(); m_ready = 1'b0; ex_valid = 1'b0; #1;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL fw_late_ready got=%b exp=0", wb_valid); end
    cyc(); #1;
    total++; if (wb_valid !== 1'b0 || m_op_count !== 32'd4) begin bad++; $display("FAIL fw_count got=%b %0d exp=0 4", wb_valid, m_op_count); end
  endtask

  task automatic test_flush_drain();
    cyc(); put(3'b000, 5'd3, 32'd2, 32'd2); #1;
    cyc(); #1;
    cyc(); flush = 1'b1; ex_valid = 1'b0; #1;
    cyc(); #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL fd_flush_in_drain got=%b exp=0", stall); end
    cyc(); flush = 1'b0; put(3'b001, 5'd9, 32'd11, 32'd13); #1;
    total++; if (stall !== 1'b1 || m_valid !== 1'b0) begin bad++; $display("FAIL fd_mulh_held got=%b%b exp=10", stall, m_valid); end
    cyc(); #1;
    total++; if (stall !== 1'b1 || m_rd !== 5'd3) begin bad++; $display("FAIL fd_hold2 got=%b %0d exp=1 3", stall, m_rd); end
    cyc(); m_ready = 1'b1; m_result = 32'd77; #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL fd_ready_stall got=%b exp=1", stall); end
    cyc(); m_ready = 1'b0; #1;
    total++; if (stall !== 1'b1 || m_valid !== 1'b0 || wb_valid !== 1'b0) begin bad++; $display("FAIL fd_launch got=%b%b%b exp=100", stall, m_valid, wb_valid); end
    cyc(); #1;
    total++; if (m_valid !== 1'b1 || m_rd !== 5'd9 || m_rs1 !== 32'd11) begin bad++; $display("FAIL fd_issue got=%b %0d %0d exp=1 9 11", m_valid, m_rd, m_rs1); end
    cyc(); m_ready = 1'b1; m_result = 32'h55; #1;
    cyc(); m_ready = 1'b0; wb_ready = 1'b1; #1;
    total++; if (wb_valid !== 1'b1 || wb_rd !== 5'd9 || wb_data !== 32'h55) begin bad++; $display("FAIL fd_wb got=%b %0d %h exp=1 9 55", wb_valid, wb_rd, wb_data); end
    cyc(); wb_ready = 1'b0; ex_valid = 1'b0; #1;
    total++; if (m_op_count !== 32'd5) begin bad++; $display("FAIL fd_count got=%0d exp=5", m_op_count); end
  endtask

  task automatic test_timeout();
    int e;
    e = 0;
    resetn = 1'b1; cyc(); cyc(); resetn = 1'b0;
    m_wr = 1'b0;
    put(3'b000, 5'd10, 32'd1, 32'd2); #1;
    cyc(); #1;
    total++; if (wd_m_valid !== 1'b1) begin bad++; $display("FAIL to_issue got=%b exp=1", wd_m_valid); end
    for (int k = 1; k <= 7; k++) begin
      cyc(); #1;
      if (wd_wb_valid !== 1'b0 || wd_timeout_err !== 1'b0 || wd_stall !== 1'b1) e++;
    end
    total++; if (e !== 0) begin bad++; $display("FAIL to_early got=%0d bad cycles exp=0", e); end
    cyc(); wb_ready = 1'b1; #1;
    total++; if (wd_wb_valid !== 1'b1 || wd_timeout_err !== 1'b1) begin bad++; $display("FAIL to_done got=%b %b exp=1 1", wd_wb_valid, wd_timeout_err); end
    total++; if (wd_wb_data !== 32'hFFFF_FFFF || wd_wb_we !== 1'b1 || wd_wb_rd !== 5'd10) begin bad++; $display("FAIL to_wb got=%h %b %0d exp=ffffffff 1 10", wd_wb_data, wd_wb_we, wd_wb_rd); end
    total++; if (wb_valid !== 1'b0 || timeout_err !== 1'b0) begin bad++; $display("FAIL to_long_dut got=%b %b exp=0 0", wb_valid, timeout_err); end
    cyc(); wb_ready = 1'b0; ex_valid = 1'b0; #1;
    total++; if (wd_m_op_count !== 32'd1) begin bad++; $display("FAIL to_count got=%0d exp=1", wd_m_op_count); end
    repeat (5) cyc();
    total++; if (wd_timeout_err !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b exp=1", wd_timeout_err); end
    resetn = 1'b1; #1;
    total++; if (wd_timeout_err !== 1'b0 || wd_m_op_count !== 32'd0) begin bad++; $display("FAIL to_reset got=%b %0d exp=0 0", wd_timeout_err, wd_m_op_count); end
    cyc(); resetn = 1'b0;
  endtask

  task automatic test_reset_mid();
    m_wr = 1'b1;
    cyc(); put(3'b000, 5'd12, 32'd2, 32'd9); #1;
    cyc(); #1;
    cyc(); #1;
    cyc(); m_ready = 1'b1; m_result = 32'd18; #1;
    #2; resetn = 1'b1; ex_valid = 1'b0; m_ready = 1'b0; #1;
    total++; if ({m_valid, stall, wb_valid, wb_we, timeout_err} !== 5'b0) begin bad++; $display("FAIL rm_flags got=%b exp=00000", {m_valid, stall, wb_valid, wb_we, timeout_err}); end
    total++; if ({m_instruction, m_rs1, m_rs2, m_rd, wb_data, wb_rd} !== '0) begin bad++; $display("FAIL rm_regs got=%h %h %h %h exp=0", m_instruction, m_rs1, m_rs2, wb_data); end
    cyc(); cyc(); resetn = 1'b0;
    put(3'b000, 5'd12, 32'd2, 32'd9); #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL rm_relaunch got=%b exp=1", stall); end
    cyc(); #1;
    total++; if (m_valid !== 1'b1 || m_rs2 !== 32'd9) begin bad++; $display("FAIL rm_issue got=%b %0d exp=1 9", m_valid, m_rs2); end
    cyc(); m_ready = 1'b1; m_result = 32'd18; #1;
    cyc(); m_ready = 1'b0; wb_ready = 1'b1; #1;
    total++; if (wb_valid !== 1'b1 || wb_data !== 32'd18 || wb_rd !== 5'd12) begin bad++; $display("FAIL rm_wb got=%b %0d %0d exp=1 18 12", wb_valid, wb_data, wb_rd); end
    cyc(); wb_ready = 1'b0; ex_valid = 1'b0; #1;
    total++; if (m_op_count !== 32'd1) begin bad++; $display("FAIL rm_count got=%0d exp=1", m_op_count); end
  endtask

  initial begin
    resetn = 1'b1;
    ex_valid = 1'b0; ex_instruction = '0; ex_rs1_val = '0;
    ex_rs2_val = '0; ex_rd = '0; flush = 1'b0;
    m_wr = 1'b0; m_ready = 1'b0; m_busy = 1'b0;
    m_result = '0; wb_ready = 1'b0;
    test_reset();
    test_mul();
    test_back_to_back();
    test_divu_hold();
    test_flush_wait();
    test_flush_drain();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/m_unit_scheduler.md
# m_unit_scheduler

Sequencing controller between the EX stage of the 5-stage RV32IM pipeline and the multi-cycle M-extension unit. It decodes MUL/DIV/REM instructions in EX and launches them into the M unit with a one-cycle valid pulse. It holds the pipeline while the operation is in flight, captures the result, and presents it on a writeback handshake. It also handles pipeline flushes mid-operation, a hang watchdog and a retired-operation counter.

## Interface
- TIMEOUT_CYCLES, 64: maximum WAIT cycles before the watchdog fires (≥2).
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  reset; one clock; reset is asynchronous and active-high.
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_instruction  in  32  EX instruction word.
- ex_rs1_val, ex_rs2_val  in  32 each  forwarded operand values.
- ex_rd  in  5  destination register.
- flush  in  1  pipeline flush (branch/trap); kills the EX instruction and any in-flight op.
- m_valid  out  1  launch pulse to the M unit.
- m_instruction, m_rs1, m_rs2  out  32 each  latched operation to the M unit.
- m_rd  out  5  latched destination to the M unit.
- m_wr, m_ready  in  1 each  M unit write-enable and completion.
- m_result  in  32  M unit result.
- m_busy  in  1  M unit busy; used only for assertions, not for control.
- stall  out  1  hold IF/ID/EX (combinational).
- wb_valid  out  1  result available for writeback.
- wb_we  out  1  register-file write enable for this result.
- wb_rd  out  5  writeback destination.
- wb_data  out  32  writeback data.
- wb_ready  in  1  writeback stage accepts the result.
- timeout_err  out  1  sticky watchdog flag.
- m_op_count  out  32  number of retired M operations.

## Operation
- Decode: is_m = ex_valid && opcode==7'b0110011 && funct7==7'b0000001. launch = (state==IDLE) && is_m && !flush.
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
- IDLE:
  - On launch, latch ex_instruction, ex_rs1_val, ex_rs2_val and ex_rd into the m_* registers, then go to ISSUE.
  - stall = launch.
- ISSUE:
  - m_valid=1 for exactly this cycle; clear the watchdog counter; go to WAIT.
  - m_ready in ISSUE is ignored.
  - If flush: go to DRAIN.
  - stall=1.
- WAIT:
  - Counter increments each cycle.
  - m_ready: capture wb_data=m_result, wb_we=m_wr, wb_rd=latched rd; go to DONE.
  - If flush and m_ready are both high: discard the result and go to IDLE.
  - If flush without m_ready: go to DRAIN.
  - If counter==TIMEOUT_CYCLES-1 without m_ready: set timeout_err, wb_data=32'hFFFF_FFFF, wb_we=1; go to DONE.
  - stall=1.
- DONE:
  - wb_valid=1; stall = !wb_ready.
  - On wb_ready: increment m_op_count (wraps 0xFFFF_FFFF→0); go to IDLE. The pipeline advances on this same edge, so the completed instruction is never relaunched.
  - If flush: drop the result, no count, go to IDLE.
- DRAIN:
  - Discards the abandoned op. Waits for m_ready or watchdog expiry (timeout_err set on expiry), then goes to IDLE.
  - stall = is_m, so only new M instructions are held; non-M instructions flow.
- flush has priority over every other transition in every state.
- timeout_err clears only on reset.
- m_* outputs hold their latched values after ISSUE until the next launch.

## Timing
- Reset values: state=IDLE; every output 0, including m_* registers, wb_*, timeout_err and m_op_count.
- Reset mid-operation returns to IDLE immediately. The M unit is reset by the same signal.
- Launch detected in cycle T: stall=1 in T; m_valid=1 in T+1.
- m_ready in cycle R≥T+2: wb_valid=1 in R+1. With wb_ready=1 in R+1, stall=0 in R+1 and state=IDLE in R+2.
- Minimum launch-to-writeback latency: 3 cycles.
- A back-to-back M instruction can launch in R+2.
- Watchdog: with m_ready never asserted, DONE is entered TIMEOUT_CYCLES cycles after ISSUE.

## Test plan
- MUL x5,x1,x2 with 7 and -3, M unit ready 2 cycles after m_valid → exactly one m_valid pulse; wb_valid with wb_rd=5, wb_data=0xFFFF_FFEB; stall drops in the wb cycle; m_op_count=1.
- DIVU with a 33-cycle unit latency and wb_ready held low for 4 cycles → stall stays high throughout; wb_data stable until accepted; no second m_valid.
- flush asserted in WAIT, then a non-M ADD arrives → DRAIN; stall low for the ADD; late m_ready produces no wb_valid; m_op_count unchanged.
- flush asserted in DRAIN, then a new MULH arrives before m_ready → stall high until the drain completes; MULH launches in the cycle after m_ready.
- M unit never asserts ready, TIMEOUT_CYCLES=8 → DONE reached 8 cycles after ISSUE; wb_data=0xFFFF_FFFF; timeout_err=1 until reset.
- Reset asserted in WAIT → all outputs 0 asynchronously; the first launch after reset behaves normally.
